fpu_nibble_sequencer: RTL and testbench

//  Front-end controller for the fp16 add/mul datapath inside my_chip.
//  - Deserialises two operands that arrive 4 bits per cycle, LSB nibble first.
//  - Launches one operation on the datapath and waits for its done handshake.
//  - Returns the 16-bit result as two byte beats, low byte first, qualified by out_valid.
//  - Sits between the chip pins (io_in/io_out) and the fp16 datapath; owns all I/O sequencing.

---
 rtl/fpu_seq_pkg.sv | 33 +++
 rtl/fpu_nibble_sequencer_classify.sv | 25 ++
 rtl/fpu_nibble_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_fpu_nibble_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the fp16 nibble sequencer.
//   seq_state_e : sequencer FSM states
//   op_e        : datapath operation select (mul=0, add=1)
//   FP16_*      : fp16 field widths and bit positions
//   FLAG_*      : bit positions inside the {nan,inf,zero} status vector
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT_LO = 3'd4,
    S_OUT_HI = 3'd5
  } seq_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } op_e;

  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MAN_W   = 10;
  localparam int FP16_MAN_LSB = 0;
  localparam int FP16_MAN_MSB = FP16_MAN_W - 1;
  localparam int FP16_EXP_LSB = FP16_MAN_W;
  localparam int FP16_EXP_MSB = FP16_MAN_W + FP16_EXP_W - 1;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;

endpackage

// File: rtl/fpu_nibble_sequencer_classify.sv
// fp16_classify: combinational fp16 classifier producing {nan,inf,zero}.
// Only instantiated when FPU_SEQ_STATUS_EN is defined.
//   i_mag   in  15  fp16 value without its sign bit (sign never changes the class)
//   o_flags out 3   {nan,inf,zero}
import fpu_seq_pkg::*;

module fp16_classify (
  input  logic [14:0] i_mag,
  output logic [2:0]  o_flags
);

  logic [FP16_EXP_W-1:0] w_exp;
  logic [FP16_MAN_W-1:0] w_man;

  assign w_exp = i_mag[FP16_EXP_MSB:FP16_EXP_LSB];
  assign w_man = i_mag[FP16_MAN_MSB:FP16_MAN_LSB];

  always_comb begin
    o_flags            = '0;
    o_flags[FLAG_NAN]  = (&w_exp) && (|w_man);
    o_flags[FLAG_INF]  = (&w_exp) && !(|w_man);
    o_flags[FLAG_ZERO] = !(|w_exp) && !(|w_man);
  end

endmodule

// File: rtl/fpu_nibble_sequencer.sv
// fpu_nibble_sequencer: front-end controller for the fp16 add/mul datapath.
// Deserialises two operands arriving one nibble per cycle (LSB nibble first),
// launches a single datapath operation, waits for its done handshake and
// returns the 16-bit result as two byte beats, low byte first.
//
// Optional feature macro: FPU_SEQ_STATUS_EN
//   defined   : out_flags carries {nan,inf,zero} of the result during both beats
//   undefined : out_flags is tied to 0 and no classifier is built
//
// Ports
//   clock, reset         posedge clock, async active-high reset
//   in_nib_a/in_nib_b    operand nibbles
//   in_sel               op select (1=add, 0=mul), latched with the last nibble
//   in_en                input frame enable
//   out_byte/out_valid   result beats
//   out_flags            {nan,inf,zero} status
//   fpu_a/fpu_b/fpu_op   operands and op to datapath
//   fpu_start            one-cycle launch pulse
//   fpu_done/fpu_result  datapath completion and result
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for in_en; first in_en edge is setup edge 0
// S_LOAD   | counting in_en edges, shifting nibbles in
// S_LAUNCH | fpu_start high; done may already be high this cycle
// S_WAIT   | waiting for fpu_done (no timeout)
// S_OUT_LO | out_byte = result[7:0]
// S_OUT_HI | out_byte = result[15:8]
import fpu_seq_pkg::*;

module fpu_nibble_sequencer #(
  parameter int WORD_W       = 16,
  parameter int SETUP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        in_nib_a,
  input  logic [3:0]        in_nib_b,
  input  logic              in_sel,
  input  logic              in_en,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  output logic [2:0]        out_flags,
  output logic [WORD_W-1:0] fpu_a,
  output logic [WORD_W-1:0] fpu_b,
  output logic              fpu_op,
  output logic              fpu_start,
  input  logic              fpu_done,
  input  logic [WORD_W-1:0] fpu_result
);

  localparam int NIBBLES = WORD_W / 4;
  localparam int CNT_W   = $clog2(SETUP_CYCLES + NIBBLES + 1);
  localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETUP_CYCLES + NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SETUP_CYCLES + NIBBLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  op_e               r_op;
  logic              r_start;
  logic              r_valid;
  logic [7:0]        r_byte;
  logic [WORD_W-9:0] r_res_hi;

  logic       w_take;
  logic       w_last;
  logic       w_cap;
  logic       w_start_nxt;
  logic       w_valid_nxt;
  logic [7:0] w_byte_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_take      = 1'b0;
    w_last      = 1'b0;
    w_cap       = 1'b0;
    w_start_nxt = 1'b0;
    w_valid_nxt = 1'b0;
    w_byte_nxt  = '0;

    // r_cnt is 0 in IDLE, so with SETUP_CYCLES=0 the IDLE edge captures nibble 0.
    w_take = in_en && (r_state == S_IDLE || r_state == S_LOAD) &&
             (r_cnt >= CNT_SETUP) && (r_cnt < CNT_FULL);
    w_last = w_take && (r_cnt == CNT_LAST);

    case (r_state)
      S_IDLE: begin
        if (in_en) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_LOAD: begin
        if (in_en) begin
          // Saturate so trailing in_en edges can't wrap back into the capture window.
          w_cnt_nxt = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CNT_ONE;
        end else begin
          w_state_nxt = (r_cnt == CNT_FULL) ? S_LAUNCH : S_IDLE;
        end
      end
      S_LAUNCH, S_WAIT: begin
        if (fpu_done) begin
          w_state_nxt = S_OUT_LO;
          w_cap       = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_OUT_LO: w_state_nxt = S_OUT_HI;
      S_OUT_HI: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (w_state_nxt)
      S_LAUNCH: w_start_nxt = 1'b1;
      S_OUT_LO: begin
        w_valid_nxt = 1'b1;
        w_byte_nxt  = fpu_result[7:0];
      end
      S_OUT_HI: begin
        w_valid_nxt = 1'b1;
        w_byte_nxt  = r_res_hi[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_MUL;
      r_start  <= 1'b0;
      r_valid  <= 1'b0;
      r_byte   <= '0;
      r_res_hi <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_start <= w_start_nxt;
      r_valid <= w_valid_nxt;
      r_byte  <= w_byte_nxt;
      if (w_take) begin
        r_a <= {in_nib_a, r_a[WORD_W-1:4]};
        r_b <= {in_nib_b, r_b[WORD_W-1:4]};
      end
      if (w_last) begin
        r_op <= op_e'(in_sel);
      end
      if (w_cap) begin
        r_res_hi <= fpu_result[WORD_W-1:8];
      end
    end
  end

  assign fpu_a     = r_a;
  assign fpu_b     = r_b;
  assign fpu_op    = r_op;
  assign fpu_start = r_start;
  assign out_valid = r_valid;
  assign out_byte  = r_byte;

`ifdef FPU_SEQ_STATUS_EN
  logic [2:0] w_flags;
  logic [2:0] r_flags;

  fp16_classify u_classify (
    .i_mag   (fpu_result[14:0]),
    .o_flags (w_flags)
  );

  // Classified at the capture edge, held through OUT_HI, cleared otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_state_nxt == S_OUT_LO) begin
      r_flags <= w_flags;
    end else if (w_state_nxt != S_OUT_HI) begin
      r_flags <= '0;
    end
  end

  assign out_flags = r_flags;
`else
  assign out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_fpu_nibble_sequencer.sv
// Self-checking bench for fpu_nibble_sequencer with a behavioural datapath stub.
module tb_fpu_nibble_sequencer;

  localparam int SETUP = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_nib_a = '0;
  logic [3:0]  in_nib_b = '0;
  logic        in_sel = 1'b0;
  logic        in_en = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic [2:0]  out_flags;
  logic [15:0] fpu_a;
  logic [15:0] fpu_b;
  logic        fpu_op;
  logic        fpu_start;
  logic        fpu_done;
  logic [15:0] fpu_result;

  int n_checks = 0;
  int n_errors = 0;
  int dly  = 0;
  int dcnt = 0;
  int cyc  = 0;

  fpu_nibble_sequencer #(.WORD_W(16), .SETUP_CYCLES(SETUP)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_nib_a   (in_nib_a),
    .in_nib_b   (in_nib_b),
    .in_sel     (in_sel),
    .in_en      (in_en),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_flags  (out_flags),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_start  (fpu_start),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result)
  );

  always #5 clock = ~clock;

  // Datapath stand-in: known fp16 results for the reference vectors, a simple mix otherwise.
  function automatic logic [15:0] dp_func(input logic op, input logic [15:0] a, input logic [15:0] b);
    if (a == 16'hFFFF && b == 16'hFFFF) return 16'hFFFF;
    if (op && a == 16'h5051 && b == 16'h5051) return 16'h5451;
    if (op && a == 16'h5051 && b == 16'hD051) return 16'h0000;
    if (op && a == 16'h03FF && b == 16'h0001) return 16'h0400;
    if (!op && a == 16'h5007 && b == 16'hD007) return 16'hE40E;
    if (!op && a == 16'h7BFF && b == 16'h7BFF) return 16'h7C00;
    return op ? (a + b) : (a ^ {b[7:0], b[15:8]});
  endfunction

  function automatic logic [2:0] model_flags(input logic [15:0] r);
`ifdef FPU_SEQ_STATUS_EN
    int e;
    int m;
    e = (int'(r) >> 10) % 32;
    m = int'(r) % 1024;
    return {(e == 31 && m != 0), (e == 31 && m == 0), (e == 0 && m == 0)};
`else
    return 3'b000 & r[2:0] & 3'b000;
`endif
  endfunction

  assign fpu_result = dp_func(fpu_op, fpu_a, fpu_b);
  assign fpu_done   = (dly == 0) ? fpu_start : (dcnt == 1);

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (fpu_start && dly > 0) dcnt <= dly;
    else if (dcnt > 0) dcnt <= dcnt - 1;
  end

  // Monitor: everything here is sampled on the falling edge.
  logic [7:0]  beat_q[$];
  logic [2:0]  flag_q[$];
  int          beat_cyc_q[$];
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          unstable_cnt = 0;
  int          idle_bad_cnt = 0;
  logic [15:0] st_a = '0;
  logic [15:0] st_b = '0;
  logic        st_op = 1'b0;
  logic        in_flight = 1'b0;

  always @(negedge clock) begin
    if (fpu_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
      st_a      <= fpu_a;
      st_b      <= fpu_b;
      st_op     <= fpu_op;
    end
    if (in_flight && (fpu_a !== st_a || fpu_b !== st_b || fpu_op !== st_op))
      unstable_cnt <= unstable_cnt + 1;
    if (fpu_done && (in_flight || fpu_start)) done_cyc <= cyc;
    if (reset) in_flight <= 1'b0;
    else if (fpu_start) in_flight <= !fpu_done;
    else in_flight <= in_flight && !fpu_done;
    if (out_valid) begin
      beat_q.push_back(out_byte);
      flag_q.push_back(out_flags);
      beat_cyc_q.push_back(cyc);
    end else if (out_byte !== 8'h00 || out_flags !== 3'b000) begin
      idle_bad_cnt <= idle_bad_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] na, input logic [3:0] nb, input logic sel);
    @(negedge clock);
    in_en    = en;
    in_nib_a = na;
    in_nib_b = nb;
    in_sel   = sel;
  endtask

  task automatic drive_junk(input logic en);
    drive(en, 4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic sel,
                            input int extra, output int low_cyc);
    repeat (SETUP) drive_junk(1'b1);
    for (int i = 0; i < 4; i++)
      drive(1'b1, a[4*i +: 4], b[4*i +: 4], (i == 3) ? sel : 1'($urandom));
    repeat (extra) drive_junk(1'b1);
    drive_junk(1'b0);
    low_cyc = cyc;
  endtask

  task automatic wait_beats(input int base, input int n, input string tag);
    int k;
    k = 0;
    while (beat_q.size() < base + n && k < 80) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    check({tag, "_nbeats"}, beat_q.size() - base, n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_byte"},  out_byte, 0);
    check({tag, "_start"}, fpu_start, 0);
    check({tag, "_ops"},   {fpu_a, fpu_b}, 0);
    check({tag, "_op"},    fpu_op, 0);
    check({tag, "_flags"}, out_flags, 0);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sel, input int extra, input int d);
    int bb, bs, bu, bi, low_cyc;
    logic [15:0] r;
    dly = d;
    bb = beat_q.size();
    bs = start_cnt;
    bu = unstable_cnt;
    bi = idle_bad_cnt;
    r  = dp_func(sel, a, b);
    send_frame(a, b, sel, extra, low_cyc);
    wait_beats(bb, 2, tag);
    check({tag, "_starts"}, start_cnt - bs, 1);
    check({tag, "_start_lat"}, start_cyc - low_cyc, 1);
    check({tag, "_fpu_a"}, st_a, a);
    check({tag, "_fpu_b"}, st_b, b);
    check({tag, "_fpu_op"}, st_op, sel);
    check({tag, "_stable"}, unstable_cnt - bu, 0);
    check({tag, "_idle_out"}, idle_bad_cnt - bi, 0);
    check({tag, "_done_lat"}, done_cyc - start_cyc, d);
    if (beat_q.size() >= bb + 2) begin
      check({tag, "_lo"}, beat_q[bb], r[7:0]);
      check({tag, "_hi"}, beat_q[bb+1], r[15:8]);
      check({tag, "_flags_lo"}, flag_q[bb], model_flags(r));
      check({tag, "_flags_hi"}, flag_q[bb+1], model_flags(r));
      check({tag, "_lo_cyc"}, beat_cyc_q[bb] - done_cyc, 1);
      check({tag, "_hi_cyc"}, beat_cyc_q[bb+1] - done_cyc, 2);
    end
  endtask

  task automatic drop_frame(input int nhigh);
    int bb, bs;
    dly = 0;
    bb = beat_q.size();
    bs = start_cnt;
    repeat (nhigh) drive_junk(1'b1);
    drive_junk(1'b0);
    repeat (8) @(negedge clock);
    check($sformatf("drop%0d_starts", nhigh), start_cnt - bs, 0);
    check($sformatf("drop%0d_beats", nhigh), beat_q.size() - bb, 0);
  endtask

  // in_en kept high through LAUNCH/OUT_LO/OUT_HI; the second frame's setup edge
  // is the first edge after the return to IDLE.
  task automatic hold_pair(input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                           input logic [15:0] a2, input logic [15:0] b2, input logic s2);
    int bb, bs, lc;
    logic [15:0] r1, r2;
    dly = 0;
    bb = beat_q.size();
    bs = start_cnt;
    r1 = dp_func(s1, a1, b1);
    r2 = dp_func(s2, a2, b2);
    send_frame(a1, b1, s1, 0, lc);
    repeat (3) drive_junk(1'b1);
    send_frame(a2, b2, s2, 0, lc);
    wait_beats(bb, 4, "pair");
    check("pair_starts", start_cnt - bs, 2);
    if (beat_q.size() >= bb + 4) begin
      check("pair_b0", beat_q[bb],   r1[7:0]);
      check("pair_b1", beat_q[bb+1], r1[15:8]);
      check("pair_b2", beat_q[bb+2], r2[7:0]);
      check("pair_b3", beat_q[bb+3], r2[15:8]);
    end
  endtask

  initial begin
    int bs, k;
    repeat (3) @(negedge clock);
    #1 check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("post_reset");

    run_frame("add", 16'h5051, 16'h5051, 1'b1, 0, 0);
    run_frame("mul", 16'h5007, 16'hD007, 1'b0, 0, 0);
    hold_pair(16'h5007, 16'hD007, 1'b0, 16'h5051, 16'h5051, 1'b1);

    for (int n = 1; n <= SETUP + 3; n++) drop_frame(n);
    run_frame("after_drop", 16'h5051, 16'h5051, 1'b1, 2, 0);

    // Reset while nibble 2 is on the bus.
    dly = 0;
    bs = start_cnt;
    drive_junk(1'b1);
    drive(1'b1, 4'h3, 4'h9, 1'b0);
    drive(1'b1, 4'hC, 4'h6, 1'b0);
    drive(1'b1, 4'h5, 4'hA, 1'b1);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    @(negedge clock);
    in_en = 1'b0;
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("rst_mid_starts", start_cnt - bs, 0);
    run_frame("subnorm", 16'h03FF, 16'h0001, 1'b1, 0, 0);

    run_frame("delay5", 16'h5007, 16'hD007, 1'b0, 1, 5);
    run_frame("inf", 16'h7BFF, 16'h7BFF, 1'b0, 0, 0);
    run_frame("zero", 16'h5051, 16'hD051, 1'b1, 0, 2);
    run_frame("nan", 16'hFFFF, 16'hFFFF, 1'b0, 0, 0);

    // Reset while a beat is on the output.
    dly = 3;
    begin
      int lc;
      send_frame(16'h1234, 16'h4321, 1'b1, 0, lc);
    end
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("rst_beat_seen", out_valid, 1);
    #1 reset = 1'b1;
    #1 check_all_zero("rst_beat");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 25; i++)
      run_frame("rnd", 16'($urandom), 16'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 6)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
